// File: rtl/present_sbox_pkg.sv
// present_sbox_pkg
//   Shared constants, tables, FSM encoding and helpers for the serialized
//   PRESENT S-box layer (present_sbox_seq) and its lookup lane.
//   Tables are packed 64-bit words: nibble i of the word holds S(i).
package present_sbox_pkg;

    localparam int STATE_W = 64;
    localparam int NIB_W   = 4;
    localparam int NIB_N   = STATE_W / NIB_W;

    // Forward:  0->C 1->5 2->6 3->B 4->9 5->0 6->A 7->D 8->3 9->E A->F B->8 C->4 D->7 E->1 F->2
    localparam logic [STATE_W-1:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
    // Inverse:  0->5 1->E 2->F 3->8 4->C 5->1 6->2 7->D 8->B 9->4 A->6 B->3 C->0 D->7 E->9 F->A
    localparam logic [STATE_W-1:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of SUB cycles needed to cover all nibbles with nsbox lanes.
    function automatic int sbox_k(input int nsbox);
        return NIB_N / nsbox;
    endfunction

    function automatic bit nsbox_legal(input int nsbox);
        return (nsbox == 1) || (nsbox == 2) || (nsbox == 4) ||
               (nsbox == 8) || (nsbox == 16);
    endfunction

    function automatic logic [NIB_W-1:0] sbox_lookup(input logic [STATE_W-1:0] tbl,
                                                     input logic [NIB_W-1:0]   nib);
        return tbl[NIB_W*nib +: NIB_W];
    endfunction

endpackage

// File: rtl/present_sbox_seq_if.sv
// present_sbox_seq_if
//   Input and output valid/ready channels of present_sbox_seq.
//   in_*  : upstream state (in_valid, in_ready, in_data, in_inv)
//   out_* : substituted state (out_valid, out_ready, out_data)
//   master: the side that produces in_* and consumes out_*
//   slave : the S-box layer itself
import present_sbox_pkg::*;

interface present_sbox_seq_if;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_data;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/present_sbox_lane.sv
// present_sbox_lane
//   One combinational 4-bit PRESENT S-box lookup.
//   Build option: PRESENT_SBOX_INV_EN adds the inverse table selected by inv;
//   without it only the forward table exists and inv is ignored.
//   Ports:
//     nib  in   4  nibble to substitute
//     inv  in   1  1 = inverse table (only with PRESENT_SBOX_INV_EN)
//     sub  out  4  substituted nibble
import present_sbox_pkg::*;

module present_sbox_lane (
    input  logic [NIB_W-1:0] nib,
    input  logic             inv,
    output logic [NIB_W-1:0] sub
);

`ifdef PRESENT_SBOX_INV_EN
    assign sub = inv ? sbox_lookup(SBOX_INV, nib) : sbox_lookup(SBOX_FWD, nib);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign sub        = sbox_lookup(SBOX_FWD, nib);
`endif

endmodule

// File: rtl/present_sbox_seq.sv
// present_sbox_seq
//   Serialized PRESENT S-box layer. Accepts a 64-bit state, substitutes
//   NSBOX nibbles per cycle over K = 16/NSBOX cycles while rotating the
//   register so that nibble order is restored at the end, then presents
//   the result until the downstream takes it.
//   Build option: PRESENT_SBOX_INV_EN enables per-transaction inverse S-box
//   selection via in_inv (latched at acceptance).
//   Ports:
//     clk    in   1   rising-edge clock
//     rst    in   1   synchronous active-high reset
//     bus    slave modport of present_sbox_seq_if (in/out handshakes)
//     busy   out  1   high in SUB or DONE
//     scand  in   1   scan data in
//     scanq  out  1   scand delayed one clk edge, no reset
//   Parameter NSBOX: parallel lanes, one of 1/2/4/8/16.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | in_ready=1, waiting for an upstream state
//   SUB   | substituting NSBOX nibbles per cycle, count = cycles done
//   DONE  | out_valid=1, holding result until out_ready
import present_sbox_pkg::*;

module present_sbox_seq #(
    parameter int NSBOX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    present_sbox_seq_if.slave        bus,
    output logic                     busy,
    input  logic                     scand,
    output logic                     scanq
);

    localparam int         K        = sbox_k(NSBOX);
    localparam int         SH       = NIB_W * NSBOX;
    localparam logic [3:0] CNT_LAST = 4'(K - 1);

    if (!nsbox_legal(NSBOX)) begin : g_bad_nsbox
        $error("present_sbox_seq: NSBOX must be 1, 2, 4, 8 or 16");
    end

    state_t             state_q;
    logic [3:0]         count_q;
    logic [STATE_W-1:0] data_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               lane_inv;
    logic [SH-1:0]      lane_out;
    logic [STATE_W-1:0] sub_word;
    logic [STATE_W-1:0] rot_word;

`ifdef PRESENT_SBOX_INV_EN
    logic inv_q;
    assign lane_inv = inv_q;
`else
    logic unused_in_inv;
    assign unused_in_inv = bus.in_inv;
    assign lane_inv      = 1'b0;
`endif

    for (genvar gi = 0; gi < NSBOX; gi++) begin : g_lane
        present_sbox_lane u_lane (
            .nib (data_q[gi*NIB_W +: NIB_W]),
            .inv (lane_inv),
            .sub (lane_out[gi*NIB_W +: NIB_W])
        );
    end

    // Low SH bits substituted, then rotated right by SH so the next
    // untouched nibbles land on the lanes. With 16 lanes it is a plain load.
    if (SH == STATE_W) begin : g_full
        assign sub_word = lane_out;
        assign rot_word = sub_word;
    end else begin : g_part
        assign sub_word = {data_q[STATE_W-1:SH], lane_out};
        assign rot_word = {sub_word[SH-1:0], sub_word[STATE_W-1:SH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PRESENT_SBOX_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_q     <= bus.in_data;
`ifdef PRESENT_SBOX_INV_EN
                        inv_q      <= bus.in_inv;
`endif
                        count_q    <= '0;
                        state_q    <= SUB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SUB: begin
                    data_q  <= rot_word;
                    count_q <= count_q + 4'd1;
                    if (count_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here: no accept alongside the output handshake.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Scan passthrough lives outside the functional reset domain.
    always_ff @(posedge clk) begin
        scanq <= scand;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_present_sbox_seq.sv
// tb_present_sbox_seq
//   Three instances (NSBOX = 1, 4, 16) share clk/rst/scand; sel routes the
//   stimulus to one of them. Expected results come from a nibble-wise table
//   model and the latency rule K = 16/NSBOX.
module tb_present_sbox_seq;

`ifdef PRESENT_SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        scand;
    int          sel;
    logic        in_valid;
    logic        in_inv;
    logic        out_ready;
    logic [63:0] in_data;

    logic        out_valid;
    logic        in_ready;
    logic        busy;
    logic [63:0] out_data;
    logic [2:0]  busy_v;
    logic [2:0]  scanq_v;

    int checks = 0;
    int errors = 0;

    int          nsbox_of [3] = '{1, 4, 16};
    logic [3:0]  fwd_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0]  inv_tbl [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                  4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
    logic        scan_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    present_sbox_seq_if bus1 ();
    present_sbox_seq_if bus4 ();
    present_sbox_seq_if bus16 ();

    assign bus1.in_valid   = in_valid && (sel == 0);
    assign bus4.in_valid   = in_valid && (sel == 1);
    assign bus16.in_valid  = in_valid && (sel == 2);
    assign bus1.in_data    = in_data;
    assign bus4.in_data    = in_data;
    assign bus16.in_data   = in_data;
    assign bus1.in_inv     = in_inv;
    assign bus4.in_inv     = in_inv;
    assign bus16.in_inv    = in_inv;
    assign bus1.out_ready  = out_ready && (sel == 0);
    assign bus4.out_ready  = out_ready && (sel == 1);
    assign bus16.out_ready = out_ready && (sel == 2);

    present_sbox_seq #(.NSBOX(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy_v[0]), .scand(scand), .scanq(scanq_v[0])
    );
    present_sbox_seq #(.NSBOX(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .busy(busy_v[1]), .scand(scand), .scanq(scanq_v[1])
    );
    present_sbox_seq #(.NSBOX(16)) u_dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .busy(busy_v[2]), .scand(scand), .scanq(scanq_v[2])
    );

    always_comb begin
        out_valid = bus1.out_valid;
        in_ready  = bus1.in_ready;
        out_data  = bus1.out_data;
        busy      = busy_v[0];
        case (sel)
            1: begin
                out_valid = bus4.out_valid;
                in_ready  = bus4.in_ready;
                out_data  = bus4.out_data;
                busy      = busy_v[1];
            end
            2: begin
                out_valid = bus16.out_valid;
                in_ready  = bus16.in_ready;
                out_data  = bus16.out_data;
                busy      = busy_v[2];
            end
            default: ;
        endcase
    end

    function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            nib = d[4*i +: 4];
            r[4*i +: 4] = (inv && INV_EN) ? inv_tbl[nib] : fwd_tbl[nib];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; called at the negedge right after acceptance.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Entered and left just after a negedge with the selected DUT idle.
    task automatic send(input logic [63:0] d, input logic inv, input int hold,
                        input logic [63:0] exp, input string tag);
        int          lat;
        logic [63:0] held;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        chk({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        wait_out(lat);
        chk({tag, "/latency"}, 64'(lat), 64'(16 / nsbox_of[sel]));
        chk({tag, "/data"}, out_data, exp);
        chk({tag, "/busy_done"}, 64'(busy), 64'd1);
        chk({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "/hold_data"}, out_data, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "/in_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "/busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] junk;
        logic        inv;
        int          lat;

        rst       = 1'b1;
        scand     = 1'b0;
        sel       = 0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset/in_ready", 64'(in_ready), 64'd1);
            chk("reset/out_valid", 64'(out_valid), 64'd0);
            chk("reset/busy", 64'(busy), 64'd0);
            chk("reset/out_data", out_data, 64'd0);
        end

        sel = 0;
        #1;
        send(64'h0, 1'b0, 0, 64'hCCCC_CCCC_CCCC_CCCC, "n1_zero");
        sel = 1;
        #1;
        send(64'h0123_4567_89AB_CDEF, 1'b0, 0, 64'hC56B_90AD_3EF8_4712, "n4_ramp");
        sel = 2;
        #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 64'h2222_2222_2222_2222, "n16_ones");

`ifdef PRESENT_SBOX_INV_EN
        sel = 1;
        #1;
        send(64'hC56B_90AD_3EF8_4712, 1'b1, 0, 64'h0123_4567_89AB_CDEF, "inv_ramp");
`else
        sel = 0;
        #1;
        send(64'h0, 1'b1, 0, 64'hCCCC_CCCC_CCCC_CCCC, "inv_ignored");
`endif

        // Backpressure with in_valid held high through SUB and DONE.
        sel = 1;
        #1;
        in_inv   = 1'b0;
        in_data  = 64'h0123_4567_89AB_CDEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = {$urandom, $urandom};
        wait_out(lat);
        chk("bp/latency", 64'(lat), 64'd4);
        chk("bp/data", out_data, 64'hC56B_90AD_3EF8_4712);
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            chk("bp/hold_valid", 64'(out_valid), 64'd1);
            chk("bp/hold_data", out_data, 64'hC56B_90AD_3EF8_4712);
            chk("bp/hold_in_ready", 64'(in_ready), 64'd0);
        end
        junk      = {$urandom, $urandom};
        in_data   = junk;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp/valid_drop", 64'(out_valid), 64'd0);
        chk("bp/in_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp/next_busy", 64'(busy), 64'd1);
        wait_out(lat);
        chk("bp/next_latency", 64'(lat), 64'd4);
        chk("bp/next_data", out_data, model(junk, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Mid-flight reset on the NSBOX=1 instance, scan pattern alongside.
        sel = 0;
        #1;
        in_data  = 64'h1234_5678_9ABC_DEF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scand = scan_pat[i];
            @(negedge clk);
            chk("scan_busy/scanq", 64'(scanq_v), {61'd0, {3{scan_pat[i]}}});
        end
        chk("rst_mid/busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid/out_data", out_data, 64'd0);
        chk("rst_mid/busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        chk("rst_mid/no_late_valid", 64'(out_valid), 64'd0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 64'h2222_2222_2222_2222, "post_rst");

        // Scan path while held in reset.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scand = ~scan_pat[i];
            @(negedge clk);
            chk("scan_rst/scanq", 64'(scanq_v), {61'd0, {3{~scan_pat[i]}}});
        end
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            for (int t = 0; t < 6; t++) begin
                d   = {$urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                send(d, inv, int'($urandom_range(0, 3)), model(d, inv), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
